// File: rtl/bcd_segment_driver.sv
`timescale 1ns/1ps
// bcd_segment_driver
//   Converts a signed WIDTH-bit result into three 7-segment glyphs using a
//   sequential double-dabble engine, then drives the segment lines in step
//   with the active-low digit strobe from the digit selector.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   value_in  signed two's-complement value to display (WIDTH bits)
//   load      single-cycle convert request, honoured only when busy=0
//   busy      high while a conversion (CONVERT + COMMIT) is in progress
//   digit     active-low digit enable: 1110 ones, 1101 tens, 1011 hundreds
//   seg       active-low segments {g,f,e,d,c,b,a}, registered
//   an        active-low anode enables, registered copy of digit
module bcd_segment_driver #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value_in,
  input  logic             load,
  output logic             busy,
  input  logic [3:0]       digit,
  output logic [6:0]       seg,
  output logic [3:0]       an
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   shift_cnt;
  logic [WIDTH-1:0] mag;
  logic [15:0]     bcd;
  logic [15:0]     bcd_adj;
  logic            sign_r, ovf_r;

  logic [3:0]      disp_h, disp_t, disp_o;
  logic            disp_sign, disp_ovf;

  logic signed [15:0] val_ext;
  logic [WIDTH-1:0]   mag_in;
  logic               ovf_in;
  logic [6:0]         glyph;

  // Sign-extend to a width where the 999 / -99 limits are representable
  // for every legal WIDTH.
  assign val_ext = {{(16 - WIDTH){value_in[WIDTH-1]}}, value_in};
  assign ovf_in  = (val_ext > 16'sd999) || (val_ext < -16'sd99);
  // Negation wraps the most-negative value onto itself, which read as
  // unsigned is exactly its magnitude.
  assign mag_in  = value_in[WIDTH-1] ? ('0 - value_in) : value_in;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONVERT;
      CONVERT: if (shift_cnt == CW'(WIDTH - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_cnt <= '0;
      mag       <= '0;
      bcd       <= '0;
      sign_r    <= 1'b0;
      ovf_r     <= 1'b0;
      disp_h    <= '0;
      disp_t    <= '0;
      disp_o    <= '0;
      disp_sign <= 1'b0;
      disp_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            mag       <= mag_in;
            bcd       <= '0;
            sign_r    <= value_in[WIDTH-1];
            ovf_r     <= ovf_in;
            shift_cnt <= '0;
          end
        end
        CONVERT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          shift_cnt  <= shift_cnt + 1'b1;
        end
        COMMIT: begin
          disp_h    <= bcd[11:8];
          disp_t    <= bcd[7:4];
          disp_o    <= bcd[3:0];
          disp_sign <= sign_r;
          disp_ovf  <= ovf_r;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] digit_code(input logic [3:0] n);
    case (n)
      4'd0:    digit_code = 7'b1000000;
      4'd1:    digit_code = 7'b1111001;
      4'd2:    digit_code = 7'b0100100;
      4'd3:    digit_code = 7'b0110000;
      4'd4:    digit_code = 7'b0011001;
      4'd5:    digit_code = 7'b0010010;
      4'd6:    digit_code = 7'b0000010;
      4'd7:    digit_code = 7'b1111000;
      4'd8:    digit_code = 7'b0000000;
      4'd9:    digit_code = 7'b0010000;
      default: digit_code = GLYPH_BLANK;
    endcase
  endfunction

  always_comb begin
    glyph = GLYPH_BLANK;
    case (digit)
      4'b1110: glyph = disp_ovf ? GLYPH_R : digit_code(disp_o);
      4'b1101: begin
        if (disp_ovf)
          glyph = GLYPH_R;
        else if (disp_sign)
          glyph = (disp_t == 4'd0) ? GLYPH_BLANK : digit_code(disp_t);
        else
          glyph = (disp_h == 4'd0 && disp_t == 4'd0) ? GLYPH_BLANK : digit_code(disp_t);
      end
      4'b1011: begin
        if (disp_ovf)
          glyph = GLYPH_E;
        else if (disp_sign)
          glyph = GLYPH_MINUS;
        else
          glyph = (disp_h == 4'd0) ? GLYPH_BLANK : digit_code(disp_h);
      end
      default: glyph = GLYPH_BLANK;
    endcase
  end

  // Glyph and anode are registered together so seg/an always pair up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= '1;
      an  <= '1;
    end else begin
      seg <= glyph;
      an  <= digit;
    end
  end

endmodule

// File: tb/tb_bcd_segment_driver.sv
`timescale 1ns/1ps
module tb_bcd_segment_driver;

  localparam int W = 12;

  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_R     = 7'b0101111;
  localparam logic [6:0] G_MINUS = 7'b0111111;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] value_in;
  logic         load;
  logic         busy;
  logic [3:0]   digit;
  logic [6:0]   seg;
  logic [3:0]   an;

  bcd_segment_driver #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .value_in (value_in),
    .load     (load),
    .busy     (busy),
    .digit    (digit),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  int cur_val = 0;

  typedef struct {
    int unsigned cyc;
    logic [6:0]  seg;
    logic [3:0]  an;
  } exp_t;

  exp_t q[$];
  exp_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [6:0] dcode(input int n);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[n];
  endfunction

  // Reference: what a 3-digit display must show for an integer value.
  function automatic logic [6:0] exp_seg(input int v, input logic [3:0] d);
    logic [6:0] gh, gt, go;
    int m;
    if (v > 999 || v < -99) begin
      gh = G_E; gt = G_R; go = G_R;
    end else if (v < 0) begin
      m  = -v;
      gh = G_MINUS;
      gt = (m / 10 == 0) ? G_BLANK : dcode(m / 10);
      go = dcode(m % 10);
    end else begin
      gh = (v / 100 == 0) ? G_BLANK : dcode(v / 100);
      gt = (v < 10) ? G_BLANK : dcode((v / 10) % 10);
      go = dcode(v % 10);
    end
    case (d)
      4'b1110: return go;
      4'b1101: return gt;
      4'b1011: return gh;
      default: return G_BLANK;
    endcase
  endfunction

  // Monitor: seg/an presented each cycle are checked against queued expectations.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk("cycle_tag", cyc, e.cyc);
      chk("seg", {25'd0, seg}, {25'd0, e.seg});
      chk("an", {28'd0, an}, {28'd0, e.an});
    end
  end

  task automatic sweep(input int n_rand);
    logic [3:0] pool [7];
    logic [3:0] d;
    pool = '{4'b1110, 4'b1101, 4'b1011, 4'b1111, 4'b0111, 4'b1100, 4'b0000};
    for (int i = 0; i < 3 + n_rand; i++) begin
      if (i < 3) d = pool[2 - i];
      else       d = pool[$urandom_range(0, 6)];
      digit = d;
      q.push_back('{cyc: cyc + 1, seg: exp_seg(cur_val, d), an: d});
      @(posedge clk); #1;
    end
    digit = 4'b1111;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic load_value(input int v);
    int n;
    value_in = W'(v);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    value_in = W'($urandom);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_len", n, W + 1);
    cur_val = v;
  endtask

  initial begin
    int n;
    int fixed_vals [15];
    logic [W-1:0] r;
    fixed_vals = '{123, -45, -7, 1000, -100, 2047, -2048, 999,
                   -99, 0, 9, 10, 99, 100, -10};

    reset = 1'b1; load = 1'b0; value_in = '0; digit = 4'b1110;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_seg", {25'd0, seg}, {25'd0, G_BLANK});
    chk("reset_an", {28'd0, an}, 32'hF);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    cur_val = 0;
    sweep(2);

    foreach (fixed_vals[i]) begin
      load_value(fixed_vals[i]);
      sweep(1);
    end

    // Load during CONVERT and during COMMIT must both be dropped.
    value_in = W'(5); load = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (busy && n < 100) begin
      load = (n == 2 || n == 12);
      value_in = (n == 2 || n == 12) ? W'(321) : W'($urandom);
      @(posedge clk); #1;
      n++;
    end
    load = 1'b0;
    chk("busy_len_drop", n, W + 1);
    cur_val = 5;
    sweep(0);

    // Back-to-back: load issued on the cycle right after busy falls.
    load_value(42);
    load_value(-8);
    sweep(1);

    // Reset mid-conversion must abort without committing.
    value_in = W'(888); load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_seg", {25'd0, seg}, {25'd0, G_BLANK});
    chk("abort_an", {28'd0, an}, 32'hF);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cur_val = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_idle", {31'd0, busy}, 32'd0);
    sweep(3);

    for (int i = 0; i < 25; i++) begin
      r = W'($urandom);
      load_value($signed(r));
      sweep(3);
    end

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/bcd_segment_driver.md
# bcd_segment_driver

Converts a signed binary result from the calculator datapath into three 7-segment digit patterns and drives the segment lines in step with the active-low digit-enable strobe from the digit-select stage. It uses a sequential double-dabble engine with a load/busy handshake. Display registers update atomically on commit, so a multiplexed refresh never shows a half-converted value. The block sits directly downstream of the digit selector, between it and the board's segment/anode pins.

## Interface
- WIDTH, 12: width of the signed two's-complement input value; legal range 4..13.
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- value_in  in  WIDTH  signed result to display
- load  in  1  single-cycle request to convert value_in; sampled only when busy=0
- busy  out  1  high while a conversion is in progress; load is ignored while high
- digit  in  4  active-low digit enable from the digit selector: 1110 = ones (rightmost), 1101 = tens, 1011 = hundreds
- seg  out  7  active-low segments {g,f,e,d,c,b,a} (seg[0]=a), registered
- an  out  4  active-low anode enables, a registered copy of digit aligned with seg

## Operation
- FSM states:
  - IDLE: waiting for a load.
  - CONVERT: WIDTH shift iterations.
  - COMMIT: one cycle.
- Transitions:
  - IDLE->CONVERT on load=1.
  - CONVERT->COMMIT after the WIDTH-th shift.
  - COMMIT->IDLE unconditionally.
- Capture on accepted load:
  - sign = value_in[WIDTH-1].
  - magnitude = |value_in| as WIDTH-bit unsigned; the most-negative value is representable, e.g. -2048 -> 2048.
  - ovf = (value_in > 999) or (value_in < -99).
- Double dabble:
  - 16-bit BCD register (4 digits), cleared on load.
  - Each CONVERT cycle, add 3 to every BCD nibble >=5, then shift {bcd, mag} left one bit.
- COMMIT: copy hundreds/tens/ones nibbles, sign and ovf into the display registers. The display registers change only in COMMIT.
- Glyph per position, from the display registers:
  - If ovf: hundreds='E', tens='r', ones='r'.
  - Else if sign: hundreds='-'; tens blank when the tens nibble is 0; ones shows its digit.
  - Else: leading-zero blanking; hundreds blank when 0; tens blank when hundreds and tens are both 0; ones is always shown.
- seg codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - E=0000110, r=0101111, minus=0111111, blank=1111111
- Any digit pattern other than the three legal one-hot-low values (e.g. 1111, 0111, 1100) gives seg=1111111; an still mirrors digit.
- Reset values:
  - State IDLE, busy=0, BCD and magnitude registers 0.
  - Display registers: value 0, sign 0, ovf 0.
  - seg=1111111, an=1111.

## Timing
- Edge E0 samples load=1 in IDLE; busy=1 from E0 onward.
- Shifts happen at E1..E_WIDTH.
- The COMMIT update occurs at E_(WIDTH+1); busy=0 after E_(WIDTH+1). busy is high for exactly WIDTH+1 cycles (13 for the default).
- seg/an register digit and the display registers every edge: one-cycle latency from digit to an/seg. The first seg reflecting the new value appears after E_(WIDTH+2).
- A load in IDLE on the cycle after COMMIT is accepted.
- A load while busy=1 (CONVERT or COMMIT) is dropped, not queued.
- value_in is sampled only at the accepting edge; later changes have no effect on the conversion in progress.
- Reset asserted mid-conversion:
  - Aborts immediately, with no commit.
  - Display registers return to their reset values, so the display reads "  0" once reset deasserts.
- The digit strobe may change at any edge; seg never mixes old and new display values within one output cycle.

## Test plan
- Reset:
  - Assert reset -> seg=1111111, an=1111, busy=0.
  - Release reset, drive digit=1110 -> next cycle seg=1000000 ('0').
  - digit=1101 and digit=1011 -> seg=1111111 (blanked).
- Load 123:
  - busy is high for 13 cycles.
  - digit 1011/1101/1110 -> seg 1111001/0100100/0110000.
  - an equals digit delayed by one cycle.
- Load -45 -> hundreds=0111111, tens=0011001, ones=0010010. Load -7 -> hundreds '-', tens blank, ones 1111000.
- Load 1000, then -100, then 2047, then -2048 -> each shows E/r/r.
  - Then load 999 -> 0010000 on all three positions.
- Handshake:
  - Load 5, then pulse load with 321 three cycles later (busy=1) -> display shows 5 only, with blank blank 0010010.
  - A load on the cycle after busy falls is accepted.
- Abort and illegal strobes:
  - Load 888, assert reset at E5 -> display is "  0" after release, with no stray 8s.
  - digit=1111 and digit=0111 -> seg=1111111 for each.
